// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
// The HALT state exists only when ILLEGAL_OP_TRAP_EN is defined.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JAL      = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
        , S_HALT   = 4'd12
`endif
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded straight from the opcode so the
// extender is ready in DECODE without waiting on the state register.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [1:0] o_ImmSrc
);

    always_comb begin
        o_ImmSrc = IMM_I;
        case (i_op)
            OP_LW, OP_ITYPE, OP_JALR: o_ImmSrc = IMM_I;
            OP_SW:                    o_ImmSrc = IMM_S;
            OP_BRANCH:                o_ImmSrc = IMM_B;
            OP_JAL:                   o_ImmSrc = IMM_J;
            default:                  o_ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V core with memory-ready stalls
// and a retired-instruction counter. Optional macro: ILLEGAL_OP_TRAP_EN.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W     = 32,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [6:0]           i_op,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_AdrSrc,
    output logic                 o_IRWrite,
    output logic                 o_PCUpdate,
    output logic                 o_Branch,
    output logic                 o_RegWrite,
    output logic                 o_MemWrite,
    output logic [1:0]           o_ResultSrc,
    output logic [1:0]           o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [1:0]           o_ALUOp,
    output logic [1:0]           o_ImmSrc,
    output logic                 o_illegal,
    output logic [INSTRET_W-1:0] o_instret
);

    state_t state;
    state_t next_state;
    logic   mem_ready;

    assign mem_ready = USE_MEM_READY ? i_mem_ready : 1'b1;

    imm_src_decoder u_imm_src_decoder (
        .i_op     (i_op),
        .o_ImmSrc (o_ImmSrc)
    );

    // An instruction retires on the edge that returns the FSM to FETCH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_FETCH;
            o_instret <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_FETCH && state != S_FETCH) begin
                o_instret <= o_instret + INSTRET_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTER;
                    OP_ITYPE:     next_state = S_EXECUTEI;
                    OP_BRANCH:    next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR_ADR;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      next_state = S_HALT;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JALR_ADR: next_state = S_JAL;
            S_JAL:      next_state = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT:     next_state = S_HALT;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // Datapath controls; reset masks every enable and the memory request.
    always_comb begin
        o_mem_req   = 1'b0;
        o_AdrSrc    = 1'b0;
        o_IRWrite   = 1'b0;
        o_PCUpdate  = 1'b0;
        o_Branch    = 1'b0;
        o_RegWrite  = 1'b0;
        o_MemWrite  = 1'b0;
        o_ResultSrc = RES_ALUOUT;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_B;
        o_ALUOp     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
                o_IRWrite   = mem_ready;
                o_PCUpdate  = mem_ready;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR_ADR: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_AdrSrc  = 1'b1;
                o_mem_req = 1'b1;
            end
            S_MEMWB: begin
                o_ResultSrc = RES_DATA;
                o_RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                o_AdrSrc   = 1'b1;
                o_mem_req  = 1'b1;
                o_MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                o_ALUSrcA = SRCA_A;
                o_ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_IMM;
                o_ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    o_RegWrite = 1'b1;
            S_BEQ: begin
                o_ALUSrcA = SRCA_A;
                o_ALUOp   = ALUOP_SUB;
                o_Branch  = 1'b1;
            end
            S_JAL: begin
                o_ALUSrcA  = SRCA_OLDPC;
                o_ALUSrcB  = SRCB_FOUR;
                o_PCUpdate = 1'b1;
            end
            default: ;
        endcase
        if (i_rst) begin
            o_mem_req  = 1'b0;
            o_IRWrite  = 1'b0;
            o_PCUpdate = 1'b0;
            o_Branch   = 1'b0;
            o_RegWrite = 1'b0;
            o_MemWrite = 1'b0;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign o_illegal = (state == S_HALT);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction control microprograms are compared
// cycle by cycle against the controller under random memory wait states.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [6:0]  i_op;
    logic        i_mem_ready;
    logic        o_mem_req, o_AdrSrc, o_IRWrite, o_PCUpdate, o_Branch;
    logic        o_RegWrite, o_MemWrite, o_illegal;
    logic [1:0]  o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_ImmSrc;
    logic [31:0] o_instret;

    int vectors     = 0;
    int miscompares = 0;
    int exp_instret = 0;

    // mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, ResultSrc, SrcA, SrcB, ALUOp
    typedef struct packed {
        logic mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write;
        logic [1:0] result_src, src_a, src_b, alu_op;
    } ctl_t;
    typedef struct packed { ctl_t w; logic mem; } step_t;

    localparam ctl_t W_FETCH   = 15'b1011000_10_00_10_00;
    localparam ctl_t W_DECODE  = 15'b0000000_00_01_01_00;
    localparam ctl_t W_ADDRESS = 15'b0000000_00_10_01_00;
    localparam ctl_t W_LOAD    = 15'b1100000_00_00_00_00;
    localparam ctl_t W_LOADWB  = 15'b0000010_01_00_00_00;
    localparam ctl_t W_STORE   = 15'b1100001_00_00_00_00;
    localparam ctl_t W_ALU_RR  = 15'b0000000_00_10_00_10;
    localparam ctl_t W_ALU_RI  = 15'b0000000_00_10_01_10;
    localparam ctl_t W_WRITEBK = 15'b0000010_00_00_00_00;
    localparam ctl_t W_BRANCH  = 15'b0000100_00_10_00_01;
    localparam ctl_t W_JUMP    = 15'b0001000_00_01_10_00;
    localparam ctl_t W_QUIET   = 15'b0000000_00_00_00_00;

    step_t seq[$];

    multicycle_controller dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_op        (i_op),
        .i_mem_ready (i_mem_ready),
        .o_mem_req   (o_mem_req),
        .o_AdrSrc    (o_AdrSrc),
        .o_IRWrite   (o_IRWrite),
        .o_PCUpdate  (o_PCUpdate),
        .o_Branch    (o_Branch),
        .o_RegWrite  (o_RegWrite),
        .o_MemWrite  (o_MemWrite),
        .o_ResultSrc (o_ResultSrc),
        .o_ALUSrcA   (o_ALUSrcA),
        .o_ALUSrcB   (o_ALUSrcB),
        .o_ALUOp     (o_ALUOp),
        .o_ImmSrc    (o_ImmSrc),
        .o_illegal   (o_illegal),
        .o_instret   (o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic ctl_t observed();
        return {o_mem_req, o_AdrSrc, o_IRWrite, o_PCUpdate, o_Branch, o_RegWrite,
                o_MemWrite, o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == OP_SW)     return 2'b01;
        if (op == OP_BRANCH) return 2'b10;
        if (op == OP_JAL)    return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    // Reference microprogram: the control word of every cycle of one instruction.
    function automatic void build(input logic [6:0] op);
        seq.delete();
        seq.push_back({W_FETCH, 1'b1});
        seq.push_back({W_DECODE, 1'b0});
        case (op)
            OP_LW:     begin seq.push_back({W_ADDRESS, 1'b0}); seq.push_back({W_LOAD, 1'b1});
                             seq.push_back({W_LOADWB, 1'b0}); end
            OP_SW:     begin seq.push_back({W_ADDRESS, 1'b0}); seq.push_back({W_STORE, 1'b1}); end
            OP_RTYPE:  begin seq.push_back({W_ALU_RR, 1'b0}); seq.push_back({W_WRITEBK, 1'b0}); end
            OP_ITYPE:  begin seq.push_back({W_ALU_RI, 1'b0}); seq.push_back({W_WRITEBK, 1'b0}); end
            OP_BRANCH: seq.push_back({W_BRANCH, 1'b0});
            OP_JAL:    begin seq.push_back({W_JUMP, 1'b0}); seq.push_back({W_WRITEBK, 1'b0}); end
            OP_JALR:   begin seq.push_back({W_ADDRESS, 1'b0}); seq.push_back({W_JUMP, 1'b0});
                             seq.push_back({W_WRITEBK, 1'b0}); end
            default: ;
        endcase
    endfunction

    // Runs one instruction from FETCH, checking every cycle; memory steps
    // see 'fetch_wait' / 'mem_wait' not-ready cycles before completing.
    task automatic run_instruction(input string name, input logic [6:0] op,
                                   input int fetch_wait, input int mem_wait,
                                   output int cycles, output int ir_pulses, output int mw_cycles);
        ctl_t exp;
        int   n;
        build(op);
        cycles = 0; ir_pulses = 0; mw_cycles = 0;
        foreach (seq[k]) begin
            n = seq[k].mem ? ((seq[k].w == W_FETCH) ? fetch_wait : mem_wait) : 0;
            for (int c = 0; c <= n; c++) begin
                @(negedge i_clk);
                i_rst = 1'b0;
                i_op  = op;
                i_mem_ready = seq[k].mem ? (c == n) : 1'($urandom_range(0, 1));
                #1;
                exp = seq[k].w;
                if (exp == W_FETCH && !i_mem_ready) begin
                    exp.ir_write  = 1'b0;
                    exp.pc_update = 1'b0;
                end
                vectors++;
                if (observed() !== exp || o_ImmSrc !== exp_imm(op) ||
                    o_instret !== 32'(exp_instret) || o_illegal !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s step %0d cycle %0d: got ctl=%b imm=%b instret=%0d illegal=%b, expected ctl=%b imm=%b instret=%0d illegal=0",
                             name, k, c, observed(), o_ImmSrc, o_instret, o_illegal,
                             exp, exp_imm(op), exp_instret);
                end
                cycles++;
                if (o_IRWrite)  ir_pulses++;
                if (o_MemWrite) mw_cycles++;
            end
        end
`ifdef ILLEGAL_OP_TRAP_EN
        if (is_legal(op)) exp_instret++;
`else
        exp_instret++;
`endif
    endtask

    task automatic test_reset();
        int cy, ir, mw;
        ctl_t exp;
        i_rst = 1'b1; i_mem_ready = 1'b1; i_op = OP_RTYPE;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        exp = W_FETCH; exp.mem_req = 1'b0; exp.ir_write = 1'b0; exp.pc_update = 1'b0;
        vectors++;
        if (observed() !== exp || o_instret !== 32'd0 || o_illegal !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got ctl=%b instret=%0d illegal=%b, expected ctl=%b instret=0 illegal=0",
                     observed(), o_instret, o_illegal, exp);
        end
        exp_instret = 0;
        run_instruction("reset_rtype", OP_RTYPE, 0, 0, cy, ir, mw);
        // Walk a store into its wait and pull reset mid-access.
        i_op = OP_SW;
        repeat (3) begin
            @(negedge i_clk); i_mem_ready = 1'b1;
        end
        repeat (2) begin
            @(negedge i_clk); i_mem_ready = 1'b0; #1;
            vectors++;
            if (o_MemWrite !== 1'b1 || o_AdrSrc !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL sw_wait_before_reset: got MemWrite=%b AdrSrc=%b, expected 1 1", o_MemWrite, o_AdrSrc);
            end
        end
        @(negedge i_clk); i_rst = 1'b1; #1;
        vectors++;
        if (o_MemWrite !== 1'b0 || o_mem_req !== 1'b0 || o_AdrSrc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_memwrite: got MemWrite=%b mem_req=%b AdrSrc=%b, expected 0 0 1",
                     o_MemWrite, o_mem_req, o_AdrSrc);
        end
        @(negedge i_clk); i_rst = 1'b0; i_mem_ready = 1'b0; #1;
        exp = W_FETCH; exp.ir_write = 1'b0; exp.pc_update = 1'b0;
        exp_instret = 0;
        vectors++;
        if (observed() !== exp || o_instret !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL after_reset_fetch: got ctl=%b instret=%0d, expected ctl=%b instret=0",
                     observed(), o_instret, exp);
        end
    endtask

    task automatic test_rtype();
        int cy, ir, mw;
        run_instruction("rtype", OP_RTYPE, 0, 0, cy, ir, mw);
        vectors++;
        if (cy !== 4) begin
            miscompares++;
            $display("[TB] FAIL rtype_latency: got %0d cycles, expected 4", cy);
        end
    endtask

    task automatic test_lw_waits();
        int cy, ir, mw;
        run_instruction("lw_wait", OP_LW, 3, 2, cy, ir, mw);
        vectors++;
        if (cy !== 10 || ir !== 1) begin
            miscompares++;
            $display("[TB] FAIL lw_wait_totals: got cycles=%0d irwrite_pulses=%0d, expected cycles=10 irwrite_pulses=1", cy, ir);
        end
    endtask

    task automatic test_sw_waits();
        int cy, ir, mw;
        run_instruction("sw_wait", OP_SW, 0, 2, cy, ir, mw);
        vectors++;
        if (mw !== 3 || cy !== 6) begin
            miscompares++;
            $display("[TB] FAIL sw_wait_totals: got memwrite_cycles=%0d cycles=%0d, expected memwrite_cycles=3 cycles=6", mw, cy);
        end
    endtask

    task automatic test_jalr();
        int cy, ir, mw;
        run_instruction("jalr", OP_JALR, 0, 0, cy, ir, mw);
        vectors++;
        if (cy !== 5) begin
            miscompares++;
            $display("[TB] FAIL jalr_latency: got %0d cycles, expected 5", cy);
        end
    endtask

    task automatic test_back_to_back();
        int cy, ir, mw;
        logic [6:0] ops [7] = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR};
        for (int i = 0; i < 40; i++) begin
            run_instruction("random", ops[$urandom_range(0, 6)], $urandom_range(0, 3),
                            $urandom_range(0, 3), cy, ir, mw);
        end
    endtask

    task automatic test_illegal();
        int cy, ir, mw;
        run_instruction("illegal_op", 7'b1111111, 0, 0, cy, ir, mw);
`ifdef ILLEGAL_OP_TRAP_EN
        repeat (3) begin
            @(negedge i_clk); i_mem_ready = 1'($urandom_range(0, 1)); #1;
            vectors++;
            if (observed() !== W_QUIET || o_illegal !== 1'b1 || o_instret !== 32'(exp_instret)) begin
                miscompares++;
                $display("[TB] FAIL halt_hold: got ctl=%b illegal=%b instret=%0d, expected ctl=%b illegal=1 instret=%0d",
                         observed(), o_illegal, o_instret, W_QUIET, exp_instret);
            end
        end
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0; i_mem_ready = 1'b0; #1;
        exp_instret = 0;
        vectors++;
        if (o_illegal !== 1'b0 || o_instret !== 32'd0 || o_mem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_release: got illegal=%b instret=%0d mem_req=%b, expected 0 0 1",
                     o_illegal, o_instret, o_mem_req);
        end
`endif
        run_instruction("after_illegal", OP_ITYPE, 1, 0, cy, ir, mw);
    endtask

    initial begin
        i_rst = 1'b1; i_mem_ready = 1'b0; i_op = 7'b0;
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw_waits();
        test_jalr();
        test_back_to_back();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore FSM control unit for the multicycle RISC-V core variant. It shares one ALU and one unified instruction/data memory across the cycles of each instruction: fetch, decode, execute, memory access and writeback. It drives all mux selects and write enables for the datapath, stalls on a memory-ready handshake, and counts retired instructions. Supported instructions are lw, sw, R-type, I-type ALU, beq/bne, jal and jalr.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter o_instret.
USE_MEM_READY, 1, when 0 i_mem_ready is ignored and treated as constant 1.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_op  input  7  opcode from the instruction register, stable after FETCH
i_mem_ready  input  1  memory completes the current access this cycle
o_mem_req  output  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
o_AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
o_IRWrite  output  1  instruction register / OldPC load enable
o_PCUpdate  output  1  unconditional PC load
o_Branch  output  1  conditional PC load, qualified by the datapath with Zero
o_RegWrite  output  1  register file write enable
o_MemWrite  output  1  memory write strobe
o_ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
o_ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A
o_ALUSrcB  output  2  00 = B (WriteData), 01 = ImmExt, 10 = constant 4
o_ALUOp  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
o_ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J; combinational from i_op, 00 for other opcodes
o_illegal  output  1  sticky illegal-opcode flag (see Optional Feature)
o_instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset: synchronous and active-high. While i_rst=1, IRWrite, PCUpdate, RegWrite, MemWrite, Branch and mem_req are forced to 0. At the next edge: state=FETCH, o_instret=0, o_illegal=0.
- Reset asserted in any state, including mid-wait, returns the FSM to FETCH at the next edge. No enable is asserted during the reset cycle.
- Outputs are a pure decode of the state register (Moore), except o_ImmSrc and the ready-gated enables. Every output not listed for a state is 0.
- FETCH outputs: AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only in the cycle i_mem_ready=1. The FSM holds in FETCH while i_mem_ready=0, then goes to DECODE.
- DECODE outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut = branch/jal target). Next state by i_op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - any other opcode -> see Optional Feature
- MEMADR outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: MEMREAD if lw, else MEMWRITE.
- MEMREAD outputs: ResultSrc=00, AdrSrc=1, mem_req=1. Holds until ready, then MEMWB.
- MEMWB outputs: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE outputs: ResultSrc=00, AdrSrc=1, mem_req=1, MemWrite=1, held for the entire wait. Holds until ready, then FETCH.
- EXECUTER outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECUTEI outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB outputs: ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
- JALR_ADR outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut = rs1+imm). Next state JAL.
- JAL outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB (rd = OldPC+4).
- Latencies, with zero wait states: lw 5 cycles; sw, R-type, I-type, jal 4 cycles; beq 3 cycles; jalr 5 cycles.
- o_instret increments by 1 on every edge where the next state is FETCH and the current state is not FETCH. It wraps modulo 2^INSTRET_W.
- With USE_MEM_READY=0, every wait state is exactly one cycle.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to state HALT. In HALT all enables and mem_req are 0 and o_illegal=1. The FSM stays in HALT until i_rst, and o_instret does not increment.
- Undefined: an unknown opcode in DECODE goes to FETCH and executes as a NOP. It counts as retired, o_illegal is tied 0, and the HALT state is not built.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - state encoding constants
  - ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc encoding constants
- One sub-module, imm_src_decoder: combinational i_op -> o_ImmSrc.

Test Plan:
- Reset, then 1 cycle with i_rst=1 in mid-MEMWRITE wait -> state=FETCH, MemWrite=0 during the reset cycle, o_instret=0.
- R-type 0110011, ready always 1 -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite high only in cycle 4; o_instret +1.
- lw with i_mem_ready low for 3 cycles in FETCH and 2 cycles in MEMREAD -> IRWrite/PCUpdate pulse exactly once; 10 total cycles; RegWrite with ResultSrc=01 in MEMWB.
- sw with ready delayed 2 cycles -> MemWrite=1 and AdrSrc=1 for 3 consecutive cycles, then FETCH.
- jalr 1100111 -> sequence DECODE, JALR_ADR (ALUSrcA=10, ALUSrcB=01), JAL (PCUpdate=1), ALUWB (RegWrite=1).
- Opcode 1111111 -> with ILLEGAL_OP_TRAP_EN: HALT, o_illegal=1, count frozen; without: back to FETCH after 2 cycles, o_instret +1.
